alu_issue_ctrl: RTL and testbench

- Sequential front-end that drives the control and operand inputs of the team's 16-bit ALU (a, b, cin, ainvert, bnegate, less, op) and captures its outputs (result, cout, overflow).
- Accepts function requests on a valid/ready port and returns registered results and flags on a second valid/ready port.
- Runs SLT/SLTU as two ALU passes, because the ALU's `less` input is external.
- Sits between the datapath issue logic and the ALU instance.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_func_decode.sv | 45 ++++
 rtl/alu_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Function codes, ALU op encodings and controller state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] FN_AND  = 4'd0;
    localparam logic [3:0] FN_OR   = 4'd1;
    localparam logic [3:0] FN_ADD  = 4'd2;
    localparam logic [3:0] FN_SUB  = 4'd3;
    localparam logic [3:0] FN_NOR  = 4'd4;
    localparam logic [3:0] FN_XOR  = 4'd5;
    localparam logic [3:0] FN_SLT  = 4'd6;
    localparam logic [3:0] FN_SLTU = 4'd7;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_LESS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SETLT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic       ainvert;
        logic       bnegate;
        logic       cin;
        logic [2:0] op;
        logic       two_pass;
        logic       illegal;
    } alu_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/alu_func_decode.sv
// ============================================================================
// Module : alu_func_decode
// Brief  : Maps a request function code onto ALU control fields.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_func_decode
    import alu_pkg::*;
(
    input  logic [3:0] i_func,
    output alu_ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_func)
            FN_AND:  o_ctrl.op = OP_AND;
            FN_OR:   o_ctrl.op = OP_OR;
            FN_ADD:  o_ctrl.op = OP_ADD;
            FN_SUB: begin
                o_ctrl.bnegate = 1'b1;
                o_ctrl.cin     = 1'b1;
                o_ctrl.op      = OP_ADD;
            end
            // ~a & ~b == ~(a | b)
            FN_NOR: begin
                o_ctrl.ainvert = 1'b1;
                o_ctrl.bnegate = 1'b1;
                o_ctrl.op      = OP_AND;
            end
            FN_XOR:  o_ctrl.op = OP_XOR;
            FN_SLT, FN_SLTU: begin
                o_ctrl.bnegate  = 1'b1;
                o_ctrl.cin      = 1'b1;
                o_ctrl.op       = OP_ADD;
                o_ctrl.two_pass = 1'b1;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module : alu_issue_ctrl
// Brief  : Valid/ready front-end sequencing requests through an external ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_func,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic             alu_ainvert,
    output logic             alu_bnegate,
    output logic             alu_less,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_illegal
);

    state_t           state_q,   state_d;
    logic [3:0]       func_q,    func_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;
    logic             illegal_q, illegal_d;

    logic [3:0]       w_dec_func;
    alu_ctrl_t        w_ctrl;
    logic             w_lt;

    // One decoder serves both the accept decision and the execute pass.
    assign w_dec_func = (state_q == ST_IDLE) ? req_func : func_q;

    alu_func_decode u_decode (
        .i_func (w_dec_func),
        .o_ctrl (w_ctrl)
    );

    // The subtract-pass flags are already registered when SETLT runs.
    assign w_lt = (func_q == FN_SLTU) ? ~cout_q : (result_q[WIDTH-1] ^ ovf_q);

    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        req_ready   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_cin     = 1'b0;
        alu_ainvert = 1'b0;
        alu_bnegate = 1'b0;
        alu_less    = 1'b0;
        alu_op      = 3'b000;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    func_d    = req_func;
                    a_d       = req_a;
                    b_d       = req_b;
                    result_d  = '0;
                    cout_d    = 1'b0;
                    ovf_d     = 1'b0;
                    illegal_d = w_ctrl.illegal;
                    state_d   = w_ctrl.illegal ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_a       = a_q;
                alu_b       = b_q;
                alu_cin     = w_ctrl.cin;
                alu_ainvert = w_ctrl.ainvert;
                alu_bnegate = w_ctrl.bnegate;
                alu_op      = w_ctrl.op;
                result_d    = alu_result;
                // Carry/overflow only carry meaning on the adder path.
                cout_d      = (w_ctrl.op == OP_ADD) ? alu_cout     : 1'b0;
                ovf_d       = (w_ctrl.op == OP_ADD) ? alu_overflow : 1'b0;
                state_d     = w_ctrl.two_pass ? ST_SETLT : ST_RESP;
            end
            ST_SETLT: begin
                alu_op   = OP_LESS;
                alu_less = w_lt;
                result_d = alu_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            func_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_result   = result_q;
    assign rsp_cout     = cout_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = rsp_valid && (result_q == '0);
    assign rsp_illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module : tb_alu_issue_ctrl
// Brief  : Directed vector bench for alu_issue_ctrl with a behavioural 16-bit ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_func;
    logic [WIDTH-1:0] req_a, req_b;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic             alu_cin, alu_ainvert, alu_bnegate, alu_less;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout, alu_overflow;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout, rsp_overflow, rsp_zero, rsp_illegal;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_func     (req_func),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cin      (alu_cin),
        .alu_ainvert  (alu_ainvert),
        .alu_bnegate  (alu_bnegate),
        .alu_less     (alu_less),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_cout     (rsp_cout),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_illegal  (rsp_illegal)
    );

    // Behavioural stand-in for the 16-bit ALU.
    logic [WIDTH-1:0] m_aa, m_bb;
    logic [WIDTH:0]   m_sum;
    always_comb begin
        m_aa         = alu_ainvert ? ~alu_a : alu_a;
        m_bb         = alu_bnegate ? ~alu_b : alu_b;
        m_sum        = {1'b0, m_aa} + {1'b0, m_bb} + {{WIDTH{1'b0}}, alu_cin};
        alu_cout     = m_sum[WIDTH];
        alu_overflow = (m_aa[WIDTH-1] == m_bb[WIDTH-1]) && (m_sum[WIDTH-1] != m_aa[WIDTH-1]);
        alu_result   = '0;
        case (alu_op)
            3'b000:  alu_result = m_aa & m_bb;
            3'b010:  alu_result = m_aa | m_bb;
            3'b100:  alu_result = m_sum[WIDTH-1:0];
            3'b110:  alu_result = m_aa ^ m_bb;
            3'b111:  alu_result = {{(WIDTH-1){1'b0}}, alu_less};
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [3:0]       func;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
        logic             ill;
        int               lat;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_alu_idle(input string name);
        check(name, {25'd0, alu_a, alu_b, alu_cin, alu_ainvert, alu_bnegate, alu_less, alu_op}, 64'd0);
    endtask

    // Issue one request from IDLE and wait for rsp_valid; leaves the bench
    // #1 after the edge at which the response appeared.
    task automatic issue(input vec_t v, output bit got);
        int lat;
        check("req_ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_func  = v.func;
        req_a     = v.a;
        req_b     = v.b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_func  = '0;
        req_a     = '0;
        req_b     = '0;
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        got = rsp_valid;
        if (!got) begin
            n_vec++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid expected within 8 cycles");
            return;
        end
        check("latency",      lat,          v.lat);
        check("rsp_result",   rsp_result,   v.res);
        check("rsp_cout",     rsp_cout,     v.cout);
        check("rsp_overflow", rsp_overflow, v.ovf);
        check("rsp_zero",     rsp_zero,     (v.res == '0));
        check("rsp_illegal",  rsp_illegal,  v.ill);
        check("req_ready_busy", {63'd0, req_ready}, 64'd0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_valid_after", {63'd0, rsp_valid}, 64'd0);
        check("req_ready_after", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        bit   got;
        vec_t v;

        vecs[0]  = '{FN_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1};
        vecs[1]  = '{FN_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{FN_NOR,  16'h0002, 16'h0001, 16'hFFFC, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{FN_SLT,  16'hFFFF, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 2};
        vecs[4]  = '{FN_SLTU, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 2};
        vecs[5]  = '{FN_SLT,  16'h8000, 16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0, 2};
        vecs[6]  = '{FN_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{FN_OR,   16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{FN_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{FN_SUB,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{FN_XOR,  16'h00F0, 16'h0FF0, 16'h0F00, 1'b0, 1'b0, 1'b0, 1};
        vecs[11] = '{FN_SLTU, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2};
        vecs[12] = '{4'd9,    16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 0};
        vecs[13] = '{4'd15,   16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 0};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_func  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("reset_req_ready", {63'd0, req_ready}, 64'd1);
        check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset_rsp_outs", {44'd0, rsp_result, rsp_cout, rsp_overflow, rsp_zero, rsp_illegal}, 64'd0);
        check_alu_idle("reset_alu_outs");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i], got);
            if (got) begin
                if (vecs[i].ill) check_alu_idle("illegal_alu_outs");
                handshake();
            end
        end

        // Backpressure: response must hold while rsp_ready is low.
        rsp_ready = 1'b0;
        issue(vecs[10], got);
        if (got) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                check("bp_rsp_valid",  {63'd0, rsp_valid}, 64'd1);
                check("bp_rsp_result", rsp_result, 64'h0F00);
                check("bp_req_ready",  {63'd0, req_ready}, 64'd0);
            end
            handshake();
        end

        // Reset while the SLT second pass is on the ALU.
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_func  = FN_SLT;
        req_a     = 16'hFFFF;
        req_b     = 16'h0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("setlt_alu_op",   alu_op,   OP_LESS);
        check("setlt_alu_less", alu_less, 1'b1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_mid_req_ready", {63'd0, req_ready}, 64'd1);
        check_alu_idle("rst_mid_alu_outs");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        v = '{FN_ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1};
        issue(v, got);
        if (got) handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
